// File: rtl/mux_n1_rr_reg.sv
// N-input, W-bit registered multiplexer with valid/ready handshakes.
// A channel is chosen either by an external select or by round-robin
// arbitration. The chosen word lands in a single output register that
// the consumer drains with out_valid/out_ready.
module mux_n1_rr_reg #(
    parameter int WIDTH  = 2,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode_rr,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    // Channel count in the widened index domain used for the wrap-around.
    localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W+1)'(NUM_IN);
    // Pointer reset value: the last channel, so channel 0 wins first.
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_IN-1);

    logic [WIDTH-1:0]  out_data_r;
    logic              out_valid_r;
    logic [SEL_W-1:0]  out_src_r;
    logic [SEL_W-1:0]  last_r;

    logic              ld_s;
    logic              grant_valid_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic [SEL_W:0]    cand_s;
    logic [WIDTH-1:0]  grant_data_s;
    logic [NUM_IN-1:0] in_ready_s;

    // The output register can take a new word when empty or being drained.
    assign ld_s = !out_valid_r || out_ready;

    // Grant selection: fixed select, or rotating search starting after last_r.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {SEL_W{1'b0}};
        cand_s        = {(SEL_W+1){1'b0}};
        if (mode_rr) begin
            for (int k = 1; k <= NUM_IN; k++) begin
                cand_s = {1'b0, last_r} + (SEL_W+1)'(k);
                if (cand_s >= NUM_IN_L) begin
                    cand_s = cand_s - NUM_IN_L;
                end else begin
                    cand_s = cand_s;
                end
                for (int i = 0; i < NUM_IN; i++) begin
                    if (!grant_valid_s && (cand_s == (SEL_W+1)'(i)) && in_valid[i]) begin
                        grant_valid_s = 1'b1;
                        grant_idx_s   = SEL_W'(i);
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
        end else begin
            // Only indices below NUM_IN are ever matched, so an
            // out-of-range sel simply never grants.
            for (int i = 0; i < NUM_IN; i++) begin
                if (({1'b0, sel} == (SEL_W+1)'(i)) && in_valid[i]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = SEL_W'(i);
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end
    end

    // Data mux for the granted channel and the one-hot (or zero) ready vector.
    always_comb begin
        grant_data_s = {WIDTH{1'b0}};
        in_ready_s   = {NUM_IN{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_valid_s && (grant_idx_s == SEL_W'(i))) begin
                grant_data_s  = in_data[i*WIDTH +: WIDTH];
                in_ready_s[i] = reset_L && ld_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;

    // Output register and round-robin pointer; holds everything under backpressure.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_src_r   <= {SEL_W{1'b0}};
            last_r      <= LAST_RST;
        end else if (ld_s) begin
            if (grant_valid_s) begin
                out_data_r  <= grant_data_s;
                out_src_r   <= grant_idx_s;
                out_valid_r <= 1'b1;
                if (mode_rr) begin
                    last_r <= grant_idx_s;
                end else begin
                    last_r <= last_r;
                end
            end else begin
                // Nothing to load: the register empties, old word is kept.
                out_valid_r <= 1'b0;
            end
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
            out_src_r   <= out_src_r;
            last_r      <= last_r;
        end
    end

endmodule

// File: tb/tb_mux_n1_rr_reg.sv
// Scenario bench for mux_n1_rr_reg: a 4-channel instance checked against a
// reference model with an output-word queue, plus a 3-channel instance for
// the out-of-range select case.
module tb_mux_n1_rr_reg;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] in_data;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic       mode_rr;
    logic [1:0] sel;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_src;

    logic [5:0] in_data3;
    logic [2:0] in_valid3;
    logic [2:0] in_ready3;
    logic       mode_rr3;
    logic [1:0] sel3;
    logic [1:0] out_data3;
    logic       out_valid3;
    logic       out_ready3;
    logic [1:0] out_src3;

    int vecs = 0;
    int errs = 0;

    // Reference model state: output-register occupancy, pointer, word queue.
    logic       m_valid;
    int         m_last;
    logic [3:0] q[$];      // {src, data} of the word expected in the output register

    logic       exp_ld;
    logic       exp_gv;
    logic [1:0] exp_g;
    logic [3:0] exp_ready;
    int         c_tb;

    always #5 clk = ~clk;

    mux_n1_rr_reg #(.WIDTH(2), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .reset_L(reset_L), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode_rr(mode_rr), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
    );

    mux_n1_rr_reg #(.WIDTH(2), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset_L(reset_L), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode_rr(mode_rr3), .sel(sel3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_src(out_src3)
    );

    // Expected grant and ready vector of the 4-channel instance.
    always_comb begin
        exp_ld = !m_valid || out_ready;
        exp_gv = 1'b0;
        exp_g  = 2'd0;
        c_tb   = 0;
        if (!mode_rr) begin
            if (in_valid[sel]) begin
                exp_gv = 1'b1;
                exp_g  = sel;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                c_tb = (m_last + k) % 4;
                if (!exp_gv && in_valid[c_tb]) begin
                    exp_gv = 1'b1;
                    exp_g  = 2'(c_tb);
                end
            end
        end
        exp_ready = (reset_L && exp_ld && exp_gv) ? (4'b0001 << exp_g) : 4'b0000;
    end

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = 3;
        q.delete();
    endtask

    // Advance the model by one edge using the pre-edge inputs, then clock.
    task automatic tick();
        if (m_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (reset_L && exp_ld && exp_gv) begin
            q.push_back({exp_g, in_data[exp_g*2 +: 2]});
            m_valid = 1'b1;
            if (mode_rr) m_last = int'(exp_g);
        end else if (reset_L && exp_ld) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0; in_valid = 4'hF; in_data = 8'hE4; mode_rr = 1'b1;
        sel = 2'd0; out_ready = 1'b1;
        in_data3 = 6'd0; in_valid3 = 3'd0; mode_rr3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if ({out_data, out_src, out_valid} !== 5'b0) begin
            errs++; $display("FAIL reset_state: got %b expected 00000", {out_data, out_src, out_valid});
        end
        vecs++;
        if (in_ready !== 4'b0000) begin
            errs++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        reset_L = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 4'b0001 || in_ready !== exp_ready) begin
            errs++; $display("FAIL first_grant: got %b expected 0001", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (out_valid !== 1'b1 || out_src !== 2'(i) || {out_src, out_data} !== q[0]) begin
                errs++; $display("FAIL reset_stream: got v=%b src=%0d data=%0d expected v=1 src=%0d data=%0d",
                                 out_valid, out_src, out_data, i, i);
            end
        end
        #2;
        reset_L = 1'b0;
        #1;
        vecs++;
        if ({out_data, out_src, out_valid} !== 5'b0 || in_ready !== 4'b0000) begin
            errs++; $display("FAIL async_reset: got out=%b rdy=%b expected out=00000 rdy=0000",
                             {out_data, out_src, out_valid}, in_ready);
        end
        model_reset();
        #1;
        reset_L = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 4'b0001 || in_ready !== exp_ready) begin
            errs++; $display("FAIL post_reset_grant: got %b expected 0001", in_ready);
        end
    endtask

    task automatic test_fixed();
        mode_rr = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 8'hE4; out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (in_ready !== 4'b0100 || in_ready !== exp_ready) begin
                errs++; $display("FAIL fixed_ready: got %b expected 0100", in_ready);
            end
            tick();
            vecs++;
            if (out_valid !== 1'b1 || out_data !== 2'd2 || out_src !== 2'd2 || {out_src, out_data} !== q[0]) begin
                errs++; $display("FAIL fixed_out: got v=%b src=%0d data=%0d expected v=1 src=2 data=2",
                                 out_valid, out_src, out_data);
            end
        end
        in_valid = 4'b1011;
        #1;
        vecs++;
        if (in_ready !== 4'b0000) begin
            errs++; $display("FAIL fixed_novalid_ready: got %b expected 0000", in_ready);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b0 || out_valid !== m_valid) begin
            errs++; $display("FAIL fixed_drop: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_rr_fair();
        logic [3:0] oh;
        mode_rr = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'($urandom);
            #1;
            oh = 4'b0001 << (i % 4);
            vecs++;
            if (in_ready !== oh || in_ready !== exp_ready) begin
                errs++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, in_ready, oh);
            end
            tick();
            vecs++;
            if (out_valid !== 1'b1 || out_src !== 2'(i % 4) || {out_src, out_data} !== q[0]) begin
                errs++; $display("FAIL rr_out[%0d]: got v=%b src=%0d data=%0d expected v=1 src=%0d data=%0d",
                                 i, out_valid, out_src, out_data, i % 4, q[0][1:0]);
            end
        end
    endtask

    task automatic test_sparse();
        in_valid = 4'b0010;
        #1;
        vecs++;
        if (in_ready !== 4'b0010) begin
            errs++; $display("FAIL sparse_setup: got %b expected 0010", in_ready);
        end
        tick();
        in_valid = 4'b1001; in_data = 8'hE4;
        #1;
        vecs++;
        if (in_ready !== 4'b1000 || in_ready !== exp_ready) begin
            errs++; $display("FAIL sparse_ch3_ready: got %b expected 1000", in_ready);
        end
        tick();
        vecs++;
        if (out_src !== 2'd3 || out_data !== 2'd3 || out_valid !== 1'b1) begin
            errs++; $display("FAIL sparse_ch3_out: got src=%0d data=%0d expected src=3 data=3", out_src, out_data);
        end
        vecs++;
        if (in_ready !== 4'b0001 || in_ready !== exp_ready) begin
            errs++; $display("FAIL sparse_wrap_ready: got %b expected 0001", in_ready);
        end
        tick();
        vecs++;
        if (out_src !== 2'd0 || out_data !== 2'd0 || {out_src, out_data} !== q[0]) begin
            errs++; $display("FAIL sparse_wrap_out: got src=%0d data=%0d expected src=0 data=0", out_src, out_data);
        end
    endtask

    task automatic test_backpressure();
        mode_rr = 1'b1; in_valid = 4'hF; in_data = 8'hE4; out_ready = 1'b1;
        #1;
        tick();
        vecs++;
        if (out_data !== 2'd1 || out_src !== 2'd1 || out_valid !== 1'b1) begin
            errs++; $display("FAIL bp_setup: got src=%0d data=%0d expected src=1 data=1", out_src, out_data);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            #1;
            vecs++;
            if (in_ready !== 4'b0000 || in_ready !== exp_ready) begin
                errs++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, in_ready);
            end
            tick();
            vecs++;
            if (out_valid !== 1'b1 || out_data !== 2'd1 || out_src !== 2'd1) begin
                errs++; $display("FAIL bp_hold[%0d]: got v=%b src=%0d data=%0d expected v=1 src=1 data=1",
                                 i, out_valid, out_src, out_data);
            end
        end
        in_data = 8'hE4; out_ready = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 4'b0100 || in_ready !== exp_ready) begin
            errs++; $display("FAIL bp_pointer: got %b expected 0100", in_ready);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 2'd2 || {out_src, out_data} !== q[0]) begin
            errs++; $display("FAIL bp_release: got v=%b src=%0d data=%0d expected v=1 src=2 data=2",
                             out_valid, out_src, out_data);
        end
    endtask

    task automatic test_invalid_sel();
        mode_rr3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; in_data3 = 6'b10_01_00; out_ready3 = 1'b0;
        #1;
        vecs++;
        if (in_ready3 !== 3'b010) begin
            errs++; $display("FAIL n3_sel1_ready: got %b expected 010", in_ready3);
        end
        tick();
        vecs++;
        if (out_valid3 !== 1'b1 || out_data3 !== 2'd1 || out_src3 !== 2'd1) begin
            errs++; $display("FAIL n3_load: got v=%b src=%0d data=%0d expected v=1 src=1 data=1",
                             out_valid3, out_src3, out_data3);
        end
        sel3 = 2'd3;
        #1;
        vecs++;
        if (in_ready3 !== 3'b000) begin
            errs++; $display("FAIL n3_sel3_stall_ready: got %b expected 000", in_ready3);
        end
        tick();
        vecs++;
        if (out_valid3 !== 1'b1 || out_data3 !== 2'd1) begin
            errs++; $display("FAIL n3_pending: got v=%b data=%0d expected v=1 data=1", out_valid3, out_data3);
        end
        out_ready3 = 1'b1;
        #1;
        vecs++;
        if (in_ready3 !== 3'b000) begin
            errs++; $display("FAIL n3_sel3_ready: got %b expected 000", in_ready3);
        end
        tick();
        vecs++;
        if (out_valid3 !== 1'b0) begin
            errs++; $display("FAIL n3_drain: got out_valid=%b expected 0", out_valid3);
        end
        sel3 = 2'd2;
        #1;
        vecs++;
        if (in_ready3 !== 3'b100) begin
            errs++; $display("FAIL n3_sel2_ready: got %b expected 100", in_ready3);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_fair();
        test_sparse();
        test_backpressure();
        test_invalid_sel();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
